lsu_mem_master: RTL and testbench

- CPU-side initiator for the Data_memory port (Addr, WriteData, MemWrite, MemRead, DMout).
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Loads: issues a doubleword read, extracts the addressed byte/half/word/dword, and sign- or zero-extends it.
- Stores: sub-doubleword stores are done as read-modify-write; full doubleword stores are a single write.

---
 rtl/lsu_mem_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store master for a single-ported doubleword Data_memory.
// It accepts one request at a time over a valid/ready handshake.
// Loads read the whole doubleword and return the addressed field, sign- or zero-extended.
// Partial stores use read-modify-write; full doubleword stores are a single write.
// Only REGSIZE = 64 is supported. RD_CYCLES must be in the range 1..7.
module lsu_mem_master #(
  parameter int REGSIZE   = 64,
  parameter int RD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [REGSIZE-1:0] req_addr,
  input  logic [REGSIZE-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [REGSIZE-1:0] resp_rdata,
  output logic               resp_err,
  output logic [REGSIZE-1:0] Addr,
  output logic [REGSIZE-1:0] WriteData,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [REGSIZE-1:0] DMout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_CYCLES);

  state_t             state, next_state;
  logic               store_q, signed_q;
  logic [1:0]         size_q;
  logic [REGSIZE-1:0] addr_q, wdata_q, rbuf;
  logic [2:0]         cnt;
  logic               accept, rd_done;
  logic [REGSIZE-1:0] line_addr, wr_shift, merged, wr_data_next, field, load_data;
  logic [7:0]         lane_en;

  // An access is misaligned when the lane offset is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign rd_done    = (state == RD) && (cnt == RD_LAST);
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign resp_rdata = (state == RESP && !store_q) ? load_data : '0;

  // The memory address is always doubleword aligned. In IDLE, the request is still on the input pins.
  assign line_addr = (state == IDLE) ? {req_addr[REGSIZE-1:3], 3'b000}
                                     : {addr_q[REGSIZE-1:3], 3'b000};

  // The only path from IDLE into WR is a full doubleword store, which writes req_wdata unchanged.
  assign wr_data_next = (state == IDLE) ? req_wdata : merged;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all clocked state uses non-blocking assignments, so every register samples its inputs from before the edge.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: next_state gets a default before the case statement, so no path leaves it unassigned and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: if (accept) begin
        if (misaligned(req_size, req_addr[2:0]))  next_state = ERR;
        else if (req_store && req_size == 2'd3)   next_state = WR;
        else                                      next_state = RD;
      end
      RD:        if (rd_done) next_state = store_q ? WR : RESP;
      WR:        next_state = RESP;
      RESP, ERR: if (resp_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Capture the request fields at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these are plain registers, not a memory array, so the async reset clears them without any cost.
    if (reset) begin
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      store_q  <= req_store;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Read-cycle counter, and capture of the memory word on the last read cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      rbuf <= '0;
    end else begin
      if (next_state == RD) cnt <= (state == RD) ? cnt + 3'd1 : 3'd1;
      else                  cnt <= '0;
      if (rd_done) rbuf <= DMout;
    end
  end

  // Registered memory interface, computed from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Addr      <= '0;
      WriteData <= '0;
    end else begin
      MemRead   <= (next_state == RD);
      MemWrite  <= (next_state == WR);
      Addr      <= (next_state == RD || next_state == WR) ? line_addr : '0;
      WriteData <= (next_state == WR) ? wr_data_next : '0;
    end
  end

  // Merge the store data into the word being read. Only the enabled byte lanes are replaced.
  always_comb begin
    case (size_q)
      2'd0:    lane_en = 8'h01;
      2'd1:    lane_en = 8'h03;
      2'd2:    lane_en = 8'h0F;
      default: lane_en = 8'hFF;
    endcase
    lane_en  = lane_en << addr_q[2:0];
    wr_shift = wdata_q << {addr_q[2:0], 3'b000};
    merged   = DMout;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = wr_shift[8*i +: 8];
    end
  end

  // Extract the addressed field from the captured word and extend it.
  always_comb begin
    field = rbuf >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    load_data = signed_q ? {{(REGSIZE-8){field[7]}}, field[7:0]}
                                    : {{(REGSIZE-8){1'b0}}, field[7:0]};
      2'd1:    load_data = signed_q ? {{(REGSIZE-16){field[15]}}, field[15:0]}
                                    : {{(REGSIZE-16){1'b0}}, field[15:0]};
      2'd2:    load_data = signed_q ? {{(REGSIZE-32){field[31]}}, field[31:0]}
                                    : {{(REGSIZE-32){1'b0}}, field[31:0]};
      default: load_data = field;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master.
// It runs directed vectors, randomized traffic against a lane-arithmetic reference model,
// backpressure, reset during a write, and a second instance with RD_CYCLES = 3.
`timescale 1ns/1ps
module tb_lsu_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_clear;
  logic        req_valid, req_ready, req_store, req_signed, resp_valid, resp_ready, resp_err;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, resp_rdata, Addr, WriteData, DMout;
  logic        MemWrite, MemRead;

  logic        r3_req_valid, r3_req_ready, r3_req_store, r3_req_signed, r3_resp_valid, r3_resp_ready, r3_resp_err;
  logic [1:0]  r3_req_size;
  logic [63:0] r3_req_addr, r3_req_wdata, r3_resp_rdata, Addr3, WriteData3, DMout3;
  logic        MemWrite3, MemRead3;

  lsu_mem_master #(.REGSIZE(64), .RD_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Addr(Addr), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead), .DMout(DMout));

  lsu_mem_master #(.REGSIZE(64), .RD_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(r3_req_valid), .req_ready(r3_req_ready), .req_store(r3_req_store),
    .req_size(r3_req_size), .req_signed(r3_req_signed), .req_addr(r3_req_addr), .req_wdata(r3_req_wdata),
    .resp_valid(r3_resp_valid), .resp_ready(r3_resp_ready), .resp_rdata(r3_resp_rdata), .resp_err(r3_resp_err),
    .Addr(Addr3), .WriteData(WriteData3), .MemWrite(MemWrite3), .MemRead(MemRead3), .DMout(DMout3));

  // Data_memory model for the main instance: combinational read, write on the rising edge.
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (mem_clear) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (MemWrite) mem[Addr[10:3]] <= WriteData;
  end
  assign DMout = MemRead ? mem[Addr[10:3]] : '0;

  // Slow read-only memory for the RD_CYCLES = 3 instance: data is valid only in the third read cycle.
  logic [2:0] rd3_hold;
  always @(posedge clk or posedge reset) begin
    if (reset) rd3_hold <= '0;
    else       rd3_hold <= MemRead3 ? rd3_hold + 3'd1 : 3'd0;
  end
  assign DMout3 = (MemRead3 && rd3_hold >= 3'd2) ? 64'hF0E1D2C3B4A59687 + 64'(Addr3[10:3])
                                                 : 64'hDEADBEEFDEADBEEF;

  // Whole-run monitors of the memory interface.
  int excl_bad = 0, idle_bad = 0;
  always @(negedge clk) begin
    if ((MemRead && MemWrite) || (MemRead3 && MemWrite3)) excl_bad++;
    if (!MemRead && !MemWrite && (Addr != 0 || WriteData != 0)) idle_bad++;
    if (!MemRead3 && !MemWrite3 && (Addr3 != 0 || WriteData3 != 0)) idle_bad++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed lane arithmetic over an array of doublewords.
  logic [63:0] ref_mem [256];
  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction
  function automatic logic [63:0] fmask(input logic [1:0] sz);
    if (sz == 2'd3) return '1;
    return (64'd1 << (8 * nbytes(sz))) - 64'd1;
  endfunction
  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [63:0] a);
    return (int'(a[2:0]) % nbytes(sz)) != 0;
  endfunction
  function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic sg, input logic [63:0] a);
    logic [63:0] m, v;
    int off;
    off = int'(a[2:0]);
    m = fmask(sz);
    v = (ref_mem[a[10:3]] >> (8 * off)) & m;
    if (sg && sz != 2'd3 && v[8 * nbytes(sz) - 1]) v = v | ~m;
    return v;
  endfunction
  function automatic void ref_store(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] m;
    int off;
    if (ref_misaligned(sz, a)) return;
    off = int'(a[2:0]);
    m = fmask(sz);
    ref_mem[a[10:3]] = (ref_mem[a[10:3]] & ~(m << (8 * off))) | ((wd & m) << (8 * off));
  endfunction

  // Runs one request with resp_ready high. The task is entered and left on a falling edge.
  // lat counts falling edges from acceptance up to the first one that sees resp_valid.
  task automatic run_txn(input logic st, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output logic er, output int lat,
                         output int nrd, output int nwr, output logic [63:0] wa, output logic [63:0] wdat);
    int n;
    rd = '0; er = 1'b0; lat = 0; nrd = 0; nwr = 0; wa = '0; wdat = '0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin check("accept_timeout", 64'(req_ready), 64'd1); return; end
    req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (lat < 50) begin
      lat++;
      if (MemRead) nrd++;
      if (MemWrite) begin nwr++; wa = Addr; wdat = WriteData; end
      if (resp_valid) break;
      @(negedge clk);
    end
    if (!resp_valid) begin check("resp_timeout", 64'(resp_valid), 64'd1); return; end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
  endtask

  task automatic run3(input logic [1:0] sz, input logic sg, input logic [63:0] a,
                      output logic [63:0] rd, output logic er, output int nrd, output int lat);
    rd = '0; er = 1'b0; nrd = 0; lat = 0;
    @(negedge clk);
    r3_req_store = 1'b0; r3_req_size = sz; r3_req_signed = sg; r3_req_addr = a; r3_req_valid = 1'b1;
    @(negedge clk);
    r3_req_valid = 1'b0;
    while (lat < 30) begin
      lat++;
      if (MemRead3) nrd++;
      if (r3_resp_valid) break;
      @(negedge clk);
    end
    if (!r3_resp_valid) check("rd3_timeout", 64'(r3_resp_valid), 64'd1);
    rd = r3_resp_rdata;
    er = r3_resp_err;
    @(negedge clk);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a, wd, exp_rd;
    logic        exp_err;
    int          exp_lat, exp_nrd, exp_nwr;
    logic [63:0] exp_wdata;
  } vec_t;
  vec_t vt [17];

  initial begin
    logic [63:0] rd, wa, wdat, exp_rd, held;
    logic        er, st, sg, exp_err;
    logic [1:0]  sz;
    logic [63:0] a, wd;
    int          lat, nrd, nwr, n, bad;

    reset = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    r3_req_valid = 1'b0; r3_req_store = 1'b0; r3_req_size = 2'd0; r3_req_signed = 1'b0;
    r3_req_addr = '0; r3_req_wdata = '0; r3_resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    //          st    sz    sg    addr   wdata                  exp_rdata              err  lat nrd nwr exp_wdata
    vt[0]  = '{1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, 64'h0,                 1'b0, 2, 0, 1, 64'h1122334455667788};
    vt[1]  = '{1'b0, 2'd3, 1'b0, 64'h40, 64'h0,                64'h1122334455667788, 1'b0, 2, 1, 0, 64'h0};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 64'h43, 64'hAB,               64'h0,                 1'b0, 3, 1, 1, 64'h11223344AB667788};
    vt[3]  = '{1'b0, 2'd3, 1'b0, 64'h40, 64'h0,                64'h11223344AB667788, 1'b0, 2, 1, 0, 64'h0};
    vt[4]  = '{1'b0, 2'd1, 1'b1, 64'h42, 64'h0,                64'hFFFFFFFFFFFFAB66, 1'b0, 2, 1, 0, 64'h0};
    vt[5]  = '{1'b0, 2'd1, 1'b0, 64'h42, 64'h0,                64'h000000000000AB66, 1'b0, 2, 1, 0, 64'h0};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 64'h46, 64'h0,                64'h0,                 1'b1, 1, 0, 0, 64'h0};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 64'h44, 64'hBEEF,             64'h0,                 1'b0, 3, 1, 1, 64'h1122BEEFAB667788};
    vt[8]  = '{1'b0, 2'd2, 1'b1, 64'h44, 64'h0,                64'h000000001122BEEF, 1'b0, 2, 1, 0, 64'h0};
    vt[9]  = '{1'b0, 2'd0, 1'b1, 64'h47, 64'h0,                64'h0000000000000011, 1'b0, 2, 1, 0, 64'h0};
    vt[10] = '{1'b0, 2'd0, 1'b1, 64'h45, 64'h0,                64'hFFFFFFFFFFFFFFBE, 1'b0, 2, 1, 0, 64'h0};
    vt[11] = '{1'b1, 2'd2, 1'b0, 64'h40, 64'hCAFEF00D,         64'h0,                 1'b0, 3, 1, 1, 64'h1122BEEFCAFEF00D};
    vt[12] = '{1'b0, 2'd3, 1'b1, 64'h40, 64'h0,                64'h1122BEEFCAFEF00D, 1'b0, 2, 1, 0, 64'h0};
    vt[13] = '{1'b1, 2'd3, 1'b0, 64'h41, 64'h5555AAAA5555AAAA, 64'h0,                 1'b1, 1, 0, 0, 64'h0};
    vt[14] = '{1'b1, 2'd0, 1'b0, 64'h40, 64'hFFFFFFFFFFFFFF5A, 64'h0,                 1'b0, 3, 1, 1, 64'h1122BEEFCAFEF05A};
    vt[15] = '{1'b0, 2'd2, 1'b1, 64'h40, 64'h0,                64'hFFFFFFFFCAFEF05A, 1'b0, 2, 1, 0, 64'h0};
    vt[16] = '{1'b0, 2'd1, 1'b1, 64'h41, 64'h0,                64'h0,                 1'b1, 1, 0, 0, 64'h0};

    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_memread", 64'(MemRead), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_addr", Addr, 64'd0);
    check("rst_writedata", WriteData, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      run_txn(vt[i].st, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, rd, er, lat, nrd, nwr, wa, wdat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      check($sformatf("vec%0d_read_cycles", i), 64'(nrd), 64'(vt[i].exp_nrd));
      check($sformatf("vec%0d_write_cycles", i), 64'(nwr), 64'(vt[i].exp_nwr));
      if (vt[i].exp_nwr != 0) begin
        check($sformatf("vec%0d_wr_addr", i), wa, {vt[i].a[63:3], 3'b000});
        check($sformatf("vec%0d_wr_data", i), wdat, vt[i].exp_wdata);
      end
      if (vt[i].st) ref_store(vt[i].sz, vt[i].a, vt[i].wd);
    end

    // Randomized traffic checked against the reference model.
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 64'($urandom_range(0, 255));
      wd = {$urandom(), $urandom()};
      exp_err = ref_misaligned(sz, a);
      exp_rd  = (!st && !exp_err) ? ref_load(sz, sg, a) : 64'd0;
      run_txn(st, sz, sg, a, wd, rd, er, lat, nrd, nwr, wa, wdat);
      check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      check($sformatf("rnd%0d_err", i), 64'(er), 64'(exp_err));
      check($sformatf("rnd%0d_latency", i), 64'(lat),
            exp_err ? 64'd1 : (st && sz == 2'd3) ? 64'd2 : st ? 64'd3 : 64'd2);
      check($sformatf("rnd%0d_read_cycles", i), 64'(nrd),
            (exp_err || (st && sz == 2'd3)) ? 64'd0 : 64'd1);
      check($sformatf("rnd%0d_write_cycles", i), 64'(nwr), (st && !exp_err) ? 64'd1 : 64'd0);
      if (st && !exp_err) begin
        ref_store(sz, a, wd);
        check($sformatf("rnd%0d_wr_addr", i), wa, {a[63:3], 3'b000});
        check($sformatf("rnd%0d_wr_data", i), wdat, ref_mem[a[10:3]]);
      end
    end

    // Backpressure: the response is held while resp_ready is low, and the pending request is not accepted.
    resp_ready = 1'b0;
    req_store = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h40; req_valid = 1'b1;
    exp_rd = ref_load(2'd3, 1'b0, 64'h40);
    n = 0; nrd = 0;
    do begin @(negedge clk); n++; if (MemRead) nrd++; end while (!resp_valid && n < 20);
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    held = resp_rdata;
    check("bp_first_rdata", held, exp_rd);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== held || req_ready || MemRead || MemWrite) bad++;
    end
    check("bp_stable_cycles", 64'(bad), 64'd0);
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("bp_released_valid", 64'(resp_valid), 64'd0);
    check("bp_released_ready", 64'(req_ready), 64'd1);
    check("bp_single_access", 64'(nrd), 64'd1);

    // Reset during the WR cycle of a byte store aborts the store without a response.
    req_store = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 64'h4B; req_wdata = 64'h77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!MemWrite && n < 10) begin @(negedge clk); n++; end
    check("rst_mid_reached_wr", 64'(MemWrite), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_memwrite_drop", 64'(MemWrite), 64'd0);
    check("rst_mid_addr_zero", Addr, 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (4) begin @(negedge clk); if (resp_valid || !req_ready) bad++; end
    check("rst_mid_no_response", 64'(bad), 64'd0);
    check("rst_mid_mem_untouched", mem[9], ref_mem[9]);

    // RD_CYCLES = 3: MemRead is held for exactly three cycles, and the data from the third cycle is used.
    run3(2'd3, 1'b0, 64'h40, rd, er, nrd, lat);
    check("rd3_dword_rdata", rd, 64'hF0E1D2C3B4A5968F);
    check("rd3_dword_read_cycles", 64'(nrd), 64'd3);
    check("rd3_dword_latency", 64'(lat), 64'd4);
    check("rd3_dword_err", 64'(er), 64'd0);
    run3(2'd0, 1'b1, 64'h43, rd, er, nrd, lat);
    check("rd3_byte_rdata", rd, 64'hFFFFFFFFFFFFFFB4);
    check("rd3_byte_read_cycles", 64'(nrd), 64'd3);

    check("mem_read_write_exclusive", 64'(excl_bad), 64'd0);
    check("mem_idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
